// File: rtl/histo_readout_sched.sv
// Frame-cycle scheduler for the histogram datapath: accumulate, then read, clear and serialize every bin.
// Build option HISTO_TRAILER_EN appends a 32-bit sum-of-counts trailer word after the last bin.
module histo_readout_sched #(
  parameter int NUM_BINS = 1024,
  parameter int BIN_AW   = 10,
  parameter int CNT_W    = 24,
  parameter int FID_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_valid,
  input  logic              line_valid,
  output logic              hist_wr_en,
  output logic [BIN_AW-1:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [CNT_W-1:0]  ram_rdata,
  output logic              ram_clr_en,
  output logic [31:0]       ser_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic [FID_W-1:0]  frame_id,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    RD    = 3'd2,
    CAP   = 3'd3,
`ifdef HISTO_TRAILER_EN
    SEND  = 3'd4,
    TRL   = 3'd5
`else
    SEND  = 3'd4
`endif
  } state_t;

  state_t state_r;
  logic   fv_q_r;
  logic   frame_seen_r;
  logic   fv_rise_s;
  logic   fv_fall_s;
  logic   last_bin_s;
  logic   readout_s;
`ifdef HISTO_TRAILER_EN
  logic [31:0] sum_r;
`endif

  // Frame edge detection, readout-phase decode and the accumulate gate
  always_comb begin
    fv_rise_s  = frame_valid & ~fv_q_r;
    fv_fall_s  = ~frame_valid & fv_q_r;
    last_bin_s = (ram_addr == BIN_AW'(NUM_BINS - 1));
    readout_s  = (state_r != IDLE) && (state_r != ACCUM);
    hist_wr_en = (state_r == ACCUM) & frame_valid & line_valid;
  end

  // Scheduler state, frame bookkeeping and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      fv_q_r       <= 1'b0;
      frame_seen_r <= 1'b0;
      frame_id     <= {FID_W{1'b0}};
      ram_addr     <= {BIN_AW{1'b0}};
      ram_rd_en    <= 1'b0;
      ram_clr_en   <= 1'b0;
      ser_data     <= 32'h0000_0000;
      ser_valid    <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
`ifdef HISTO_TRAILER_EN
      sum_r        <= 32'h0000_0000;
`endif
    end else begin
      fv_q_r  <= frame_valid;
      overrun <= fv_rise_s & readout_s;

      // A frame already running at reset release never saw its rise, so its end is not counted
      if (fv_rise_s) begin
        frame_seen_r <= 1'b1;
      end else if (fv_fall_s) begin
        frame_seen_r <= 1'b0;
      end else begin
        frame_seen_r <= frame_seen_r;
      end
      if (fv_fall_s && frame_seen_r) begin
        frame_id <= frame_id + FID_W'(1);
      end

      case (state_r)
        IDLE: begin
          if (fv_rise_s) begin
            state_r <= ACCUM;
            busy    <= 1'b1;
          end
        end
        ACCUM: begin
          if (fv_fall_s) begin
            state_r   <= RD;
            ram_addr  <= {BIN_AW{1'b0}};
            ram_rd_en <= 1'b1;
`ifdef HISTO_TRAILER_EN
            sum_r     <= 32'h0000_0000;
`endif
          end
        end
        RD: begin
          ram_rd_en  <= 1'b0;
          ram_clr_en <= 1'b1;
          state_r    <= CAP;
        end
        CAP: begin
          ram_clr_en <= 1'b0;
          ser_data   <= {(ram_addr == BIN_AW'(0)) ? frame_id : {FID_W{1'b0}}, ram_rdata};
          ser_valid  <= 1'b1;
          state_r    <= SEND;
`ifdef HISTO_TRAILER_EN
          sum_r      <= sum_r + {{FID_W{1'b0}}, ram_rdata};
`endif
        end
        SEND: begin
          if (ser_ready) begin
            if (last_bin_s) begin
`ifdef HISTO_TRAILER_EN
              ser_data  <= sum_r;
              state_r   <= TRL;
`else
              ser_valid <= 1'b0;
              busy      <= 1'b0;
              state_r   <= IDLE;
`endif
            end else begin
              ser_valid <= 1'b0;
              ram_addr  <= ram_addr + BIN_AW'(1);
              ram_rd_en <= 1'b1;
              state_r   <= RD;
            end
          end
        end
`ifdef HISTO_TRAILER_EN
        TRL: begin
          if (ser_ready) begin
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
`endif
        default: begin
          state_r    <= IDLE;
          ram_rd_en  <= 1'b0;
          ram_clr_en <= 1'b0;
          ser_valid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/histo_readout_sched.md
Name: histo_readout_sched

Overview:
Controls one frame cycle of the camera histogram datapath: accumulate, read out, send, clear.
- Gates pixel accumulation into the histogram RAM while a frame is active.
- At frame end, walks every bin with a read-and-clear access.
- Hands each bin to the SPI serializer as a 32-bit word, with a valid/ready handshake.
- Sits between the sensor timing inputs, the histogram bin RAM and the serializer, replacing ad-hoc edge-counted bin stepping.

Parameters:
- NUM_BINS, 1024: number of histogram bins read per frame.
- BIN_AW, 10: bin address width; log2(NUM_BINS).
- CNT_W, 24: bin count width.
- FID_W, 8: frame-ID width; CNT_W + FID_W = 32.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- frame_valid  in  1  sensor frame strobe, clk domain.
- line_valid  in  1  sensor line strobe, clk domain.
- hist_wr_en  out  1  accumulate enable to the histogram datapath.
- ram_addr  out  BIN_AW  bin address for readout and clear.
- ram_rd_en  out  1  read strobe; ram_rdata is valid on the next cycle.
- ram_rdata  in  CNT_W  bin count.
- ram_clr_en  out  1  write zero to ram_addr this cycle.
- ser_data  out  32  word to the serializer.
- ser_valid  out  1  ser_data is valid.
- ser_ready  in  1  serializer accepts the word.
- frame_id  out  FID_W  frames-ended counter.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  one-cycle pulse: a frame started during readout and was dropped.

Behaviour:
- Reset (asynchronous) values:
  - All outputs 0, state IDLE, ram_addr 0, frame_id 0.
  - The registered copy of frame_valid (fv_q) is 0.
  - A reset mid-readout abandons the transfer; RAM contents are not cleared by this block.
- Edge detection:
  - fv_rise = frame_valid & ~fv_q.
  - fv_fall = ~frame_valid & fv_q.
- States and transitions:
  - IDLE -> ACCUM on fv_rise. A frame already in progress at reset release is ignored until the next rise.
  - ACCUM: hist_wr_en = frame_valid & line_valid (combinational). On fv_fall: frame_id += 1 (wraps 2^FID_W-1 -> 0), ram_addr <= 0, go to RD.
  - RD (1 cycle): ram_rd_en = 1; go to CAP.
  - CAP (1 cycle): latch ram_rdata into the data register; ram_clr_en = 1 at the same ram_addr; go to SEND.
  - SEND: ser_valid = 1 and ser_data is held stable until ser_valid & ser_ready.
    - On the handshake with ram_addr == NUM_BINS-1: go to IDLE (or TRL, see Optional Feature).
    - On the handshake otherwise: ram_addr += 1, go to RD.
- Word format:
  - Bin 0: ser_data = {frame_id, count}.
  - All other bins: ser_data = {FID_W'h0, count}.
- Latency and throughput:
  - fv_fall is seen at cycle N; RD at N+1; ser_valid first high at N+3.
  - Minimum 3 cycles per bin with ser_ready held high.
- Frame start during RD/CAP/SEND/TRL:
  - overrun pulses for 1 cycle and hist_wr_en stays 0, so that frame is dropped.
  - frame_id still increments on that frame's fv_fall, so the host sees a gap.
  - The readout completes unaffected.
  - After the readout, return to IDLE and wait for a fresh fv_rise.
- ser_ready high while ser_valid is low is ignored.

Optional Feature:
HISTO_TRAILER_EN
- Defined:
  - After the last bin's handshake, enter TRL.
  - TRL sends one extra word: the mod-2^32 sum of all counts sent for this frame, with the same valid/ready rule, then goes to IDLE.
  - The running sum clears on entry to RD for bin 0.
- Undefined: no TRL state and no sum register; SEND at the last bin goes straight to IDLE.

Test Plan:
- Reset, then drive an 8-line frame of 16 pixels per line -> hist_wr_en high for exactly 128 cycles; frame_id goes 0 -> 1 on fv_fall; ser_valid first high 3 cycles after fv_fall is sampled.
- Preload bin0 = 5 and bin1023 = 0xABCDEF, others 0, ser_ready tied 1 -> 1024 words; word0 = 0x01000005; word1023 = 0x00ABCDEF; every bin reads 0 afterwards; busy low after the last word.
- Toggle ser_ready at random with 30% duty -> ser_data is stable throughout each valid period; the word sequence is identical to the ready-tied-high case.
- Raise frame_valid while sending bin 200 -> overrun is one pulse; hist_wr_en stays 0; the next readout's word0 tag = 0x03 (frame 2 dropped but counted).
- Assert reset at bin 500 -> all outputs 0 immediately; the next frame starts at bin 0 with frame_id tag 0x01.
- HISTO_TRAILER_EN defined with bins 0..3 = 1, 2, 3, 4 -> the 1025th word = 0x0000000A.
